pipelined_reduce_acc: RTL and testbench
=======================================

// Module: pipelined_reduce_acc
// PURPOSE
//  Pipelined, parametrised reduction tree: sums NINPUTS signed/unsigned IWIDTH operands per beat,
//  then accumulates beat sums over a multi-beat frame (e.g. a long distance/dot-product vector
//  split across beats). Registers every REG_EVERY tree levels, uses valid/ready with
//  backpressure, and saturates the frame result to OWIDTH. Successor to the combinational
//  adder tree used on the distance path.
// PARAMETERS
//  NINPUTS   2048  operands per beat; any value >=2 (non-power-of-2 is zero-padded to 2**NSTAGES)
//  IWIDTH    8     operand width
//  OWIDTH    18    signed result width
//  REG_EVERY 1     register after every REG_EVERY tree levels; 0 = fully combinational tree
//  MAX_BEATS 16    maximum beats per frame before a forced close
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               asynchronous, active-high reset
//  in_valid   in   1               beat present on d
//  in_ready   out  1               beat accepted when in_valid && in_ready
//  in_last    in   1               final beat of frame
//  in_signed  in   1               1: d is two's complement; 0: d is unsigned (per beat)
//  d          in   NINPUTS x IWIDTH operand array
//  out_valid  out  1               frame result valid; holds until out_ready
//  out_ready  in   1               downstream accepts result
//  q          out  OWIDTH          saturated signed frame sum
//  q_sat      out  1               q was clipped
//  q_beats    out  $clog2(MAX_BEATS+1)  beats summed into q
//  q_overrun  out  1               frame force-closed at MAX_BEATS without in_last
// BEHAVIOUR
//  - Reset: all pipeline valids=0, accumulator=0, beat count=0, FSM=IDLE, out_valid=0, q=0,
//    q_sat=0, q_beats=0, q_overrun=0. Reset mid-frame discards all partial data with no residue.
//  - Widths: NSTAGES=$clog2(NINPUTS). Each operand is extended to IWIDTH+1 bits (sign-extended if
//    in_signed, else zero-extended). Tree width is IWIDTH+1+NSTAGES; accumulator width is
//    IWIDTH+1+NSTAGES+$clog2(MAX_BEATS). No internal overflow. Saturation applies only at q.
//  - Pipeline: PIPE=ceil(NSTAGES/REG_EVERY) register ranks (0 if REG_EVERY=0). valid and last
//    travel with data. Beat sum reaches the accumulator stage PIPE cycles after acceptance.
//  - Latency: out_valid rises PIPE+1 cycles after the last beat is accepted, with no stall.
//  - Stall: stall = out_valid && !out_ready. in_ready = !stall. While stalled, every pipeline
//    rank, the accumulator and the FSM hold; no beat is lost or duplicated. Back-to-back frames
//    need no idle cycles.
//  - Accumulator FSM:
//    IDLE: a tree beat arrives -> acc=beat, cnt=1; if last (or MAX_BEATS==1) emit, else go to RUN.
//    RUN: each beat -> acc+=beat, cnt++; emit on last or on cnt==MAX_BEATS.
//    Emit: load q/q_sat/q_beats/q_overrun, set out_valid, go to IDLE (acc cleared).
//  - Emit/accept overlap: the next frame's first beat may enter IDLE in the same cycle the
//    previous result is accepted.
//  - Forced close: with no last by beat MAX_BEATS, that beat closes the frame and sets q_overrun=1.
//    Later beats start a new frame.
//  - Saturation: if acc > 2**(OWIDTH-1)-1, q=max and q_sat=1; if acc < -2**(OWIDTH-1), q=min and
//    q_sat=1; otherwise q=acc[OWIDTH-1:0] and q_sat=0.
//  - in_signed may change between beats of one frame; each beat is interpreted independently.
//  - out_valid deasserts the cycle after out_valid && out_ready unless a new result is emitted.
// TESTING (NINPUTS=8, IWIDTH=8, OWIDTH=12, REG_EVERY=1, MAX_BEATS=4 unless noted; PIPE=3)
//  1. One beat, all d=1, signed, last -> q=8, q_beats=1, q_sat=0; out_valid 4 cycles after accept.
//  2. Three beats, all d=-128, signed, last on beat 3 -> true sum -3072; q=-2048, q_sat=1.
//  3. One beat, all d=8'hFF: unsigned -> q=2040, q_sat=0; signed -> q=-8.
//  4. Back-to-back 1-beat frames with out_ready low for 5 cycles -> in_ready low, q stable,
//     all results delivered in order, none dropped.
//  5. Six beats of all 1s, last only on beat 6 -> first result q=32, q_beats=4, q_overrun=1;
//     second result q=16, q_beats=2.
//  6. rst pulsed after 2 beats of a frame -> out_valid=0 at once; a following 1-beat all-1 frame
//     gives q=8. Repeat with REG_EVERY=0 (latency 1) and NINPUTS=5 (zero-pad, q=5).

Source files
------------

// File: rtl/pipelined_reduce_acc.sv
// pipelined_reduce_acc
//   Pipelined reduction tree with a frame accumulator. Each accepted beat carries
//   NINPUTS operands of IWIDTH bits. Every operand is widened to IWIDTH+1 bits,
//   sign-extended when in_signed is set and zero-extended otherwise. The tree then
//   sums them into one beat total, with a register rank after every REG_EVERY
//   levels. A two-state FSM accumulates beat totals until in_last arrives or
//   MAX_BEATS beats have been summed. At that point it emits the frame sum,
//   saturated to OWIDTH signed bits.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; a beat is taken when both are high
//   in_last             marks the final beat of a frame
//   in_signed           per-beat operand interpretation (1 = two's complement)
//   d                   NINPUTS x IWIDTH operand array
//   out_valid/out_ready result handshake; the result holds until accepted
//   q, q_sat            saturated signed frame sum, and a flag set when it was clipped
//   q_beats             number of beats summed into q
//   q_overrun           frame closed at MAX_BEATS without in_last
module pipelined_reduce_acc #(
  parameter int NINPUTS   = 2048,
  parameter int IWIDTH    = 8,
  parameter int OWIDTH    = 18,
  parameter int REG_EVERY = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic                               in_signed,
  input  logic [NINPUTS-1:0][IWIDTH-1:0]     d,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OWIDTH-1:0]                  q,
  output logic                               q_sat,
  output logic [$clog2(MAX_BEATS+1)-1:0]     q_beats,
  output logic                               q_overrun
);

  localparam int NSTAGES = $clog2(NINPUTS);
  localparam int NPAD    = 1 << NSTAGES;
  localparam int NNODE   = 2 * NPAD - 1;               // all tree nodes, level 0 first
  localparam int TW      = IWIDTH + 1 + NSTAGES;       // tree width, cannot overflow
  localparam int AW      = TW + $clog2(MAX_BEATS);     // accumulator width
  localparam int CW      = $clog2(MAX_BEATS + 1);
  localparam int SW      = (AW > OWIDTH) ? AW : OWIDTH;
  localparam int RE_DIV  = (REG_EVERY == 0) ? 1 : REG_EVERY;
  localparam logic [SW-1:0] SAT_MAX = {{(SW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
  localparam logic [SW-1:0] SAT_MIN = ~SAT_MAX;

  // Nodes are stored level by level. Level l begins after all the nodes of the wider levels.
  function automatic int lvl_off(int l);
    return 2 * NPAD - 2 * (NPAD >> l);
  endfunction

  // A level is registered after every REG_EVERY levels, and the root is always registered.
  function automatic bit lvl_reg(int l);
    return (REG_EVERY != 0) && ((l % RE_DIV == 0) || (l == NSTAGES));
  endfunction

  logic              stall, accept;
  logic [TW-1:0]     node_c [NNODE];   // combinational value of each node
  logic [TW-1:0]     node_q [NNODE];   // pipeline register of each node
  logic [TW-1:0]     node   [NNODE];   // value seen by the next level
  logic [NSTAGES:1]  vld_c, lst_c, vld_q, lst_q;
  logic [NSTAGES:0]  vld, lst;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    node_c = '{default: '0};
    node   = '{default: '0};
    vld_c  = '0;
    lst_c  = '0;
    vld    = '0;
    lst    = '0;
    for (int i = 0; i < NPAD; i++) begin
      if (i < NINPUTS) node_c[i] = {{(TW-IWIDTH){in_signed & d[i][IWIDTH-1]}}, d[i]};
      node[i] = node_c[i];
    end
    vld[0] = accept;
    lst[0] = in_last;
    for (int l = 1; l <= NSTAGES; l++) begin
      for (int i = 0; i < (NPAD >> l); i++) begin
        node_c[lvl_off(l)+i] = node[lvl_off(l-1)+2*i] + node[lvl_off(l-1)+2*i+1];
        node[lvl_off(l)+i]   = lvl_reg(l) ? node_q[lvl_off(l)+i] : node_c[lvl_off(l)+i];
      end
      vld_c[l] = vld[l-1];
      lst_c[l] = lst[l-1];
      vld[l]   = lvl_reg(l) ? vld_q[l] : vld_c[l];
      lst[l]   = lvl_reg(l) ? lst_q[l] : lst_c[l];
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so all ranks shift together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (!stall) begin
      vld_q <= vld_c;
      lst_q <= lst_c;
    end
  end

  // NOTE: tree data is never consumed without its valid bit, so it carries no reset.
  // This keeps the wide operand ranks free of reset fanout.
  always_ff @(posedge clk) begin
    if (!stall) node_q <= node_c;
  end

  // Frame accumulator
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [AW-1:0]     acc_q, acc_d, beat_ext;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [SW-1:0]     acc_x;
  logic [OWIDTH-1:0] q_d;
  logic              q_sat_d, close_d, beat_v;

  assign beat_v = vld[NSTAGES] && !stall;

  always_comb begin
    beat_ext = AW'(signed'(node[NNODE-1]));
    acc_d    = (state_q == IDLE) ? beat_ext : acc_q + beat_ext;
    cnt_d    = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
    close_d  = lst[NSTAGES] || (cnt_d == CW'(MAX_BEATS));
    acc_x    = SW'(signed'(acc_d));
    q_d      = acc_x[OWIDTH-1:0];
    q_sat_d  = 1'b0;
    if ($signed(acc_x) > $signed(SAT_MAX)) begin
      q_d     = SAT_MAX[OWIDTH-1:0];
      q_sat_d = 1'b1;
    end else if ($signed(acc_x) < $signed(SAT_MIN)) begin
      q_d     = SAT_MIN[OWIDTH-1:0];
      q_sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      q         <= '0;
      q_sat     <= 1'b0;
      q_beats   <= '0;
      q_overrun <= 1'b0;
    end else begin
      // An emit in the same cycle as a handshake overrides this clear, because the later assignment wins.
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (beat_v) begin
        if (close_d) begin
          state_q   <= IDLE;
          acc_q     <= '0;
          cnt_q     <= '0;
          out_valid <= 1'b1;
          q         <= q_d;
          q_sat     <= q_sat_d;
          q_beats   <= cnt_d;
          q_overrun <= !lst[NSTAGES];
        end else begin
          state_q <= RUN;
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_reduce_acc.sv
// Bench for pipelined_reduce_acc. It uses three instances:
//   u_dut0: NINPUTS=8, REG_EVERY=1 (PIPE=3), main checks
//   u_dut1: NINPUTS=8, REG_EVERY=0 (combinational tree, latency 1)
//   u_dut2: NINPUTS=5 (zero-padded tree, PIPE=3)
// All instances use IWIDTH=8, OWIDTH=12 and MAX_BEATS=4.
module tb_pipelined_reduce_acc;
  localparam int N  = 8;
  localparam int N5 = 5;
  localparam int IW = 8;
  localparam int OW = 12;
  localparam int CW = 3;

  typedef struct packed {
    logic [OW-1:0] q;
    logic          sat;
    logic [CW-1:0] beats;
    logic          ovr;
  } res_t;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
  logic [N-1:0][IW-1:0]  d8 = '0;
  logic [N5-1:0][IW-1:0] d5 = '0;

  logic in_ready0, out_valid0, q_sat0, q_overrun0;
  logic in_ready1, out_valid1, q_sat1, q_overrun1;
  logic in_ready2, out_valid2, q_sat2, q_overrun2;
  logic [OW-1:0] q0, q1, q2;
  logic [CW-1:0] q_beats0, q_beats1, q_beats2;

  int checks = 0;
  int errors = 0;
  res_t resq[$];

  always #5 clk = ~clk;

  pipelined_reduce_acc #(.NINPUTS(N), .IWIDTH(IW), .OWIDTH(OW), .REG_EVERY(1), .MAX_BEATS(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_last(in_last),
    .in_signed(in_signed), .d(d8), .out_valid(out_valid0), .out_ready(out_ready),
    .q(q0), .q_sat(q_sat0), .q_beats(q_beats0), .q_overrun(q_overrun0));

  pipelined_reduce_acc #(.NINPUTS(N), .IWIDTH(IW), .OWIDTH(OW), .REG_EVERY(0), .MAX_BEATS(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_last(in_last),
    .in_signed(in_signed), .d(d8), .out_valid(out_valid1), .out_ready(out_ready),
    .q(q1), .q_sat(q_sat1), .q_beats(q_beats1), .q_overrun(q_overrun1));

  pipelined_reduce_acc #(.NINPUTS(N5), .IWIDTH(IW), .OWIDTH(OW), .REG_EVERY(1), .MAX_BEATS(4)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
    .in_signed(in_signed), .d(d5), .out_valid(out_valid2), .out_ready(out_ready),
    .q(q2), .q_sat(q_sat2), .q_beats(q_beats2), .q_overrun(q_overrun2));

  // Records every result that u_dut0 hands over. It samples after the bench drives its inputs.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid0 && out_ready) resq.push_back('{q: q0, sat: q_sat0, beats: q_beats0, ovr: q_overrun0});
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents one beat with every operand equal to v, and returns once it has been accepted.
  task automatic send_beat(input logic [IW-1:0] v, input logic sgn, input logic last);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_signed = sgn;
    in_last   = last;
    for (int i = 0; i < N; i++) d8[i] = v;
    for (int i = 0; i < N5; i++) d5[i] = v;
    while (!in_ready0 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready got 0 want 1");
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int k = 0; k < 40 && resq.size() < n; k++) step();
    checks++;
    if (resq.size() < n) begin
      errors++;
      $display("FAIL result_count got %0d want %0d", resq.size(), n);
    end
  endtask

  task automatic pop_result(output res_t r);
    if (resq.size() > 0) r = resq.pop_front();
    else r = 'x;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({out_valid0, q0, q_sat0, q_beats0, q_overrun0, in_ready0} !== {1'b0, 12'd0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_dut0 got %h want %h", {out_valid0, q0, q_sat0, q_beats0, q_overrun0, in_ready0},
               {1'b0, 12'd0, 1'b0, 3'd0, 1'b0, 1'b1});
    end
    checks++;
    if ({out_valid1, q1, q_sat1, q_beats1, q_overrun1, out_valid2, q2, q_sat2, q_beats2, q_overrun2} !== '0) begin
      errors++;
      $display("FAIL reset_dut12 got %h want 0", {out_valid1, q1, q_sat1, q_beats1, q_overrun1,
               out_valid2, q2, q_sat2, q_beats2, q_overrun2});
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({out_valid0, in_ready0} !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_idle got %b want 01", {out_valid0, in_ready0});
    end
  endtask

  task automatic test_single_beat();
    int   lat;
    res_t got;
    resq.delete();
    send_beat(8'd1, 1'b1, 1'b1);
    lat = 1;
    while (!out_valid0 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL t1_latency got %0d want 4", lat);
    end
    wait_results(1);
    pop_result(got);
    checks++;
    if (got !== res_t'{q: 12'd8, sat: 1'b0, beats: 3'd1, ovr: 1'b0}) begin
      errors++;
      $display("FAIL t1_result got %h want %h", got, res_t'{q: 12'd8, sat: 1'b0, beats: 3'd1, ovr: 1'b0});
    end
  endtask

  task automatic test_saturation();
    res_t got;
    resq.delete();
    // 3 x 8 x -128 = -3072 clips low. 2 x 8 x 255 = 4080 clips high.
    send_beat(8'h80, 1'b1, 1'b0);
    send_beat(8'h80, 1'b1, 1'b0);
    send_beat(8'h80, 1'b1, 1'b1);
    send_beat(8'hFF, 1'b0, 1'b0);
    send_beat(8'hFF, 1'b0, 1'b1);
    wait_results(2);
    pop_result(got);
    checks++;
    if (got !== res_t'{q: 12'h800, sat: 1'b1, beats: 3'd3, ovr: 1'b0}) begin
      errors++;
      $display("FAIL t2_sat_min got %h want %h", got, res_t'{q: 12'h800, sat: 1'b1, beats: 3'd3, ovr: 1'b0});
    end
    pop_result(got);
    checks++;
    if (got !== res_t'{q: 12'h7FF, sat: 1'b1, beats: 3'd2, ovr: 1'b0}) begin
      errors++;
      $display("FAIL t2_sat_max got %h want %h", got, res_t'{q: 12'h7FF, sat: 1'b1, beats: 3'd2, ovr: 1'b0});
    end
  endtask

  task automatic test_sign_modes();
    res_t got;
    res_t exp [3];
    exp[0] = '{q: 12'd2040, sat: 1'b0, beats: 3'd1, ovr: 1'b0};   // 8 x 255
    exp[1] = '{q: 12'hFF8,  sat: 1'b0, beats: 3'd1, ovr: 1'b0};   // 8 x -1
    exp[2] = '{q: 12'd2032, sat: 1'b0, beats: 3'd2, ovr: 1'b0};   // -8 + 2040
    resq.delete();
    send_beat(8'hFF, 1'b0, 1'b1);
    send_beat(8'hFF, 1'b1, 1'b1);
    send_beat(8'hFF, 1'b1, 1'b0);
    send_beat(8'hFF, 1'b0, 1'b1);
    wait_results(3);
    for (int k = 0; k < 3; k++) begin
      pop_result(got);
      checks++;
      if (got !== exp[k]) begin
        errors++;
        $display("FAIL t3_sign_%0d got %h want %h", k, got, exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t got;
    res_t exp;
    resq.delete();
    out_ready = 1'b0;
    // Four frames enter before the first result appears; a fifth waits on in_ready.
    for (int k = 1; k <= 4; k++) send_beat(IW'(k), 1'b1, 1'b1);
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < N; i++) d8[i] = 8'd5;
    for (int i = 0; i < N5; i++) d5[i] = 8'd5;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({in_ready0, out_valid0, q0} !== {1'b0, 1'b1, 12'd8}) begin
        errors++;
        $display("FAIL t4_stall_%0d got %h want %h", c, {in_ready0, out_valid0, q0}, {1'b0, 1'b1, 12'd8});
      end
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_results(5);
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (resq.size() != 5) begin
      errors++;
      $display("FAIL t4_total got %0d want 5", resq.size());
    end
    for (int k = 1; k <= 5; k++) begin
      exp = '{q: OW'(8 * k), sat: 1'b0, beats: 3'd1, ovr: 1'b0};
      pop_result(got);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL t4_order_%0d got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_overrun();
    res_t got;
    resq.delete();
    for (int k = 0; k < 5; k++) send_beat(8'd1, 1'b1, 1'b0);
    send_beat(8'd1, 1'b1, 1'b1);
    wait_results(2);
    pop_result(got);
    checks++;
    if (got !== res_t'{q: 12'd32, sat: 1'b0, beats: 3'd4, ovr: 1'b1}) begin
      errors++;
      $display("FAIL t5_forced got %h want %h", got, res_t'{q: 12'd32, sat: 1'b0, beats: 3'd4, ovr: 1'b1});
    end
    pop_result(got);
    checks++;
    if (got !== res_t'{q: 12'd16, sat: 1'b0, beats: 3'd2, ovr: 1'b0}) begin
      errors++;
      $display("FAIL t5_tail got %h want %h", got, res_t'{q: 12'd16, sat: 1'b0, beats: 3'd2, ovr: 1'b0});
    end
  endtask

  task automatic test_reset_mid_frame();
    int   lat;
    res_t got;
    // Hold a finished result and leave a partial frame in flight, then reset.
    out_ready = 1'b0;
    send_beat(8'd1, 1'b1, 1'b1);
    send_beat(8'd5, 1'b1, 1'b0);
    send_beat(8'd5, 1'b1, 1'b0);
    for (int k = 0; k < 20 && !out_valid0; k++) step();
    checks++;
    if (out_valid0 !== 1'b1) begin
      errors++;
      $display("FAIL t6_pending got %b want 1", out_valid0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid0, out_valid1, out_valid2, q0, q_beats0} !== '0) begin
      errors++;
      $display("FAIL t6_reset got %h want 0", {out_valid0, out_valid1, out_valid2, q0, q_beats0});
    end
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    resq.delete();
    step();
    send_beat(8'd1, 1'b1, 1'b1);
    checks++;
    if ({out_valid1, q1, q_beats1} !== {1'b1, 12'd8, 3'd1}) begin
      errors++;
      $display("FAIL t6_comb_tree got %h want %h", {out_valid1, q1, q_beats1}, {1'b1, 12'd8, 3'd1});
    end
    lat = 1;
    while (!out_valid2 && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if ({out_valid2, q2, q_beats2} !== {1'b1, 12'd5, 3'd1}) begin
      errors++;
      $display("FAIL t6_pad5 got %h want %h", {out_valid2, q2, q_beats2}, {1'b1, 12'd5, 3'd1});
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL t6_pad5_latency got %0d want 4", lat);
    end
    wait_results(1);
    pop_result(got);
    checks++;
    if (got !== res_t'{q: 12'd8, sat: 1'b0, beats: 3'd1, ovr: 1'b0}) begin
      errors++;
      $display("FAIL t6_no_residue got %h want %h", got, res_t'{q: 12'd8, sat: 1'b0, beats: 3'd1, ovr: 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_saturation();
    test_sign_modes();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
